uart_rx_fifo_feeder: RTL and testbench

- UART receiver that directly feeds the write side of the team's buffer block.
- Oversamples a serial line at 16x baud, using an internal baud-tick divider.
- Recovers 8N1 frames and presents each good byte as `rx_data` with a one-cycle `rx_wr` strobe.
- Honours the buffer's `full` flag, and reports framing errors and overruns.

---
 rtl/uart_rx_fifo_feeder.sv | 155 +++++++++++++++
 tb/tb_uart_rx_fifo_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_feeder.sv
// 16x-oversampling 8N1 UART receiver that writes each good byte into a downstream buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_fifo_feeder #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            full,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_wr,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            overrun
);

  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state;
  logic [DVSR_W-1:0] div;
  logic [S_W-1:0]    s;
  logic [N_W-1:0]    n;
  logic [DBIT-1:0]   b;
  logic [1:0]        sync;
  logic              rxs;
  logic              tick;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  assign rxs  = sync[1];
  assign tick = (div == DVSR_W'(DVSR - 1));

  // NOTE: every register here, including the shift register, is cleared on reset, so all
  // state updates use non-blocking assignments inside this one clocked block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      div       <= '0;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      sync      <= 2'b11;
      rx_data   <= '0;
      rx_wr     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], rx};
      div       <= tick ? '0 : div + 1'b1;
      rx_wr     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Tick phase is deliberately left free-running; the start bit tolerates 1 tick of jitter.
          if (!rxs) begin
            s     <= '0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s == S_W'(7)) begin
              if (!rxs) begin
                s     <= '0;
                n     <= '0;
                state <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s == S_W'(15)) begin
              s <= '0;
              b <= {rxs, b[DBIT-1:1]};
              if (n == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (s == S_W'(15)) begin
              s       <= '0;
              par_bad <= rxs ^ (^b);
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (s == S_W'(SB_TICK - 1)) begin
              state <= IDLE;
              if (!rxs) begin
                frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_err <= 1'b1;
`endif
              end else if (full) begin
                overrun <= 1'b1;
              end else begin
                rx_data <= b;
                rx_wr   <= 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed bench for uart_rx_fifo_feeder at DVSR=4 (one bit = 64 clk).
// Counts strobe cycles on the falling edge and checks them against hand-computed expectations.
module tb_uart_rx_fifo_feeder;

  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_wr;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int         n_checks = 0;
  int         n_pass = 0;
  int         wr_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] wr_data_q[$];

  uart_rx_fifo_feeder #(
    .DBIT(8), .SB_TICK(16), .DVSR(4), .DVSR_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rx),
    .full(full),
    .rx_data(rx_data),
    .rx_wr(rx_wr),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Each high cycle counts once, so a strobe stuck for two cycles shows up as an extra pulse.
  always @(negedge clk) begin
    if (rx_wr) begin
      wr_cnt++;
      wr_data_q.push_back(rx_data);
    end
    if (frame_err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int len);
    rx = v;
    wait_clks(len);
  endtask

  // word[8] is the parity bit, only transmitted when parity is compiled in.
  task automatic send_frame(input logic [8:0] word, input logic stop_v, input int stop_len);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < NBITS; i++) send_bit(word[i], BIT_CLKS);
    send_bit(stop_v, stop_len);
    rx = 1'b1;
  endtask

  function automatic logic [8:0] good(input logic [7:0] d);
    return {^d, d};
  endfunction

  initial begin
    int w0;
    int f0;

    wait_clks(5);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_wr", rx_wr, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    wait_clks(30);

    // Good frame
    w0 = wr_cnt; f0 = fe_cnt;
    send_frame(good(8'hA5), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("good_wr_count", wr_cnt - w0, 1);
    check("good_wr_data", wr_data_q[w0], 8'hA5);
    check("good_rx_data_hold", rx_data, 8'hA5);
    check("good_no_frame_err", fe_cnt - f0, 0);
    check("good_no_overrun", overrun, 0);

    // Glitch of 3 ticks on an idle line
    w0 = wr_cnt; f0 = fe_cnt;
    rx = 1'b0;
    wait_clks(12);
    rx = 1'b1;
    wait_clks(200);
    check("glitch_no_wr", wr_cnt - w0, 0);
    check("glitch_no_frame_err", fe_cnt - f0, 0);
    send_frame(good(8'h3C), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("after_glitch_wr_count", wr_cnt - w0, 1);
    check("after_glitch_data", rx_data, 8'h3C);

    // Stop bit low long enough to cover the mid-bit sample only
    w0 = wr_cnt; f0 = fe_cnt;
    send_frame(good(8'h81), 1'b0, 48);
    wait_clks(200);
    check("framing_err_count", fe_cnt - f0, 1);
    check("framing_no_wr", wr_cnt - w0, 0);
    check("framing_data_kept", rx_data, 8'h3C);

    // Overrun while downstream is full, then recovery
    w0 = wr_cnt;
    full = 1'b1;
    send_frame(good(8'h55), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("overrun_no_wr", wr_cnt - w0, 0);
    check("overrun_set", overrun, 1);
    check("overrun_data_kept", rx_data, 8'h3C);
    full = 1'b0;
    send_frame(good(8'h66), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("post_overrun_wr_count", wr_cnt - w0, 1);
    check("post_overrun_data", rx_data, 8'h66);
    check("overrun_sticky", overrun, 1);

    // Reset in the middle of data bit 4
    w0 = wr_cnt;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(1'b1, BIT_CLKS);
    send_bit(1'b0, 20);
    rx = 1'b1;
    reset_n = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(1);
    check("midreset_rx_data", rx_data, 0);
    check("midreset_rx_wr", rx_wr, 0);
    check("midreset_frame_err", frame_err, 0);
    check("midreset_overrun", overrun, 0);
    wait_clks(20);
    send_frame(good(8'h0F), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("midreset_wr_count", wr_cnt - w0, 1);
    check("midreset_wr_data", wr_data_q[w0], 8'h0F);

    // Back-to-back frames with no idle gap
    w0 = wr_cnt; f0 = fe_cnt;
`ifdef UART_RX_PARITY_EN
    pe_cnt = pe_cnt;
    begin
      int p0;
      p0 = pe_cnt;
      send_frame({1'b0, 8'h12}, 1'b1, BIT_CLKS);
      send_frame({1'b0, 8'h13}, 1'b1, BIT_CLKS);
      wait_clks(40);
      check("b2b_par_wr_count", wr_cnt - w0, 1);
      check("b2b_par_wr_data", wr_data_q[w0], 8'h12);
      check("b2b_parity_err", pe_cnt - p0, 1);
      check("b2b_par_data_kept", rx_data, 8'h12);
    end
`else
    send_frame(good(8'h12), 1'b1, BIT_CLKS);
    send_frame(good(8'h34), 1'b1, BIT_CLKS);
    wait_clks(40);
    check("b2b_wr_count", wr_cnt - w0, 2);
    check("b2b_first", wr_data_q[w0], 8'h12);
    check("b2b_second", wr_data_q[w0+1], 8'h34);
`endif
    check("b2b_no_frame_err", fe_cnt - f0, 0);

    // Line stuck low: repeated framing errors, never a write
    w0 = wr_cnt; f0 = fe_cnt;
    rx = 1'b0;
    wait_clks(2500);
    check("stuck_low_no_wr", wr_cnt - w0, 0);
    check("stuck_low_repeat_fe", 32'((fe_cnt - f0) >= 2), 1);
    rx = 1'b1;
    wait_clks(800);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
